// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings and
// the per-level stage record, sized for the widest supported operand.
package shift_pkg;

    localparam int MAX_WIDTH = 64;
    localparam int MAX_SHW   = 6;

    typedef enum logic [1:0] {
        OP_SRL = 2'd0,
        OP_SRA = 2'd1,
        OP_SLL = 2'd2,
        OP_ROR = 2'd3
    } op_e;

    typedef struct packed {
        op_e                  op;
        logic [MAX_SHW-1:0]   amount;
        logic                 sign;
        logic [MAX_WIDTH-1:0] value;
        logic                 carry;
    } stage_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: conditionally shifts by 2^LEVEL and registers the
// result together with its valid bit when the advance chain allows.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int LEVEL = 0
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   adv_i,
    input  logic   valid_i,
    input  stage_t stage_i,
    output logic   valid_o,
    output stage_t stage_o
);

    localparam int SH = 1 << LEVEL;
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> SH);

    stage_t           stage_d;
    stage_t           stage_q;
    logic             valid_q;
    logic [WIDTH-1:0] val_s;

    // Shift by 2^LEVEL when this amount bit is set; bits above WIDTH ride along untouched.
    always_comb begin
        stage_d = stage_i;
        val_s   = stage_i.value[WIDTH-1:0];
        if (stage_i.amount[LEVEL]) begin
            stage_d.amount[LEVEL] = 1'b0;
            case (stage_i.op)
                OP_SRL: begin
                    stage_d.value[WIDTH-1:0] = val_s >> SH;
                    stage_d.carry            = val_s[SH-1];
                end
                OP_SRA: begin
                    stage_d.value[WIDTH-1:0] = (val_s >> SH) |
                                               (stage_i.sign ? FILL_MASK : {WIDTH{1'b0}});
                    stage_d.carry            = val_s[SH-1];
                end
                OP_SLL: begin
                    stage_d.value[WIDTH-1:0] = val_s << SH;
                    stage_d.carry            = val_s[WIDTH-SH];
                end
                OP_ROR: begin
                    stage_d.value[WIDTH-1:0] = (val_s >> SH) | (val_s << (WIDTH - SH));
                    stage_d.carry            = val_s[SH-1];
                end
                default: begin
                    stage_d = stage_i;
                end
            endcase
        end else begin
            stage_d = stage_i;
        end
    end

    // Stage register: loads only when the downstream chain lets this level advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            stage_q <= '0;
        end else if (adv_i) begin
            valid_q <= valid_i;
            stage_q <= stage_d;
        end
    end

    assign valid_o = valid_q;
    assign stage_o = stage_q;

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter (SRL/SRA/SLL/ROR) with one registered level per
// amount bit and valid/ready handshakes on both ends.
module shift_unit
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_carry,
    output logic             out_zero
);

    stage_t           in_stage_s;
    stage_t           stage_s [SHW];
    logic [SHW-1:0]   v_s;
    logic [SHW-1:0]   adv_s;
    logic [SHW-1:0]   low_mask_s;
    logic             unused_s;

    // Pack the operand; the amount keeps only the low SHW bits, i.e. in_b mod WIDTH.
    always_comb begin
        in_stage_s                   = '0;
        in_stage_s.op                = op_e'(in_op);
        in_stage_s.amount[SHW-1:0]   = in_b[SHW-1:0];
        in_stage_s.sign              = in_a[WIDTH-1];
        in_stage_s.value[WIDTH-1:0]  = in_a;
        in_stage_s.carry             = 1'b0;
    end

    // Stage k may advance unless it and every later stage are full while the output stalls.
    always_comb begin
        adv_s      = '0;
        low_mask_s = '0;
        for (int k = 0; k < SHW; k++) begin
            low_mask_s = ~({SHW{1'b1}} << k);
            adv_s[k]   = !(&(v_s | low_mask_s)) || out_ready;
        end
    end

    for (genvar k = 0; k < SHW; k++) begin : g_level
        stage_t st_in_s;
        logic   v_in_s;
        if (k == 0) begin : g_first
            assign st_in_s = in_stage_s;
            assign v_in_s  = in_valid;
        end else begin : g_rest
            assign st_in_s = stage_s[k-1];
            assign v_in_s  = v_s[k-1];
        end
        shift_stage #(
            .WIDTH (WIDTH),
            .LEVEL (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .adv_i   (adv_s[k]),
            .valid_i (v_in_s),
            .stage_i (st_in_s),
            .valid_o (v_s[k]),
            .stage_o (stage_s[k])
        );
    end

    assign in_ready   = adv_s[0];
    assign out_valid  = v_s[SHW-1];
    assign out_result = stage_s[SHW-1].value[WIDTH-1:0];
    assign out_carry  = stage_s[SHW-1].carry;
    assign out_zero   = (out_result == {WIDTH{1'b0}});
    assign unused_s   = ^{in_b, stage_s[SHW-1]};

endmodule
